// File: rtl/onehot_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | onehot_scan_decoder                                                      |
// | Registered binary-to-one-hot decoder with a dwell-timed auto-scan mode.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module onehot_scan_decoder #(
  parameter int SEL_W = 2,
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      a,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = $clog2(DWELL+1);

  localparam logic [1:0]       c_st_idle = 2'd0;
  localparam logic [1:0]       c_st_hold = 2'd1;
  localparam logic [1:0]       c_st_scan = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL-1);
  localparam logic [SEL_W-1:0] c_idx_max  = {SEL_W{1'b1}};

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_out;
  logic             r_wrap;

  logic [SEL_W-1:0] w_idx_next;
  logic [OUT_W-1:0] w_onehot_a;
  logic [OUT_W-1:0] w_onehot_idx;
  logic [OUT_W-1:0] w_onehot_next;

  assign w_idx_next    = r_idx + SEL_W'(1);
  assign w_onehot_a    = OUT_W'(1) << a;
  assign w_onehot_idx  = OUT_W'(1) << r_idx;
  assign w_onehot_next = OUT_W'(1) << w_idx_next;

  // Priority: reset > enable > load > mode/scan advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_wrap  <= 1'b0;
    end else if (!en) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_out   <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_state <= mode ? c_st_scan : c_st_hold;
      r_idx   <= a;
      r_cnt   <= '0;
      r_out   <= w_onehot_a;
      r_wrap  <= 1'b0;
    end else if (!mode) begin
      // IDLE and HOLD keep their output; SCAN freezes at the current position.
      if (r_state == c_st_scan) begin
        r_state <= c_st_hold;
      end
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (r_state != c_st_scan) begin
      r_state <= c_st_scan;
      r_cnt   <= '0;
      r_out   <= w_onehot_idx;
      r_wrap  <= 1'b0;
    end else if (r_cnt == c_cnt_last) begin
      r_idx  <= w_idx_next;
      r_cnt  <= '0;
      r_out  <= w_onehot_next;
      r_wrap <= (r_idx == c_idx_max);
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_wrap <= 1'b0;
    end
  end

  assign out  = r_out;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_onehot_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_onehot_scan_decoder                                                   |
// | Two decoders (DWELL=1 and DWELL=3) driven in parallel against a model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, load;
  logic [1:0] a;
  logic [3:0] out1, out3;
  logic [1:0] idx1, idx3;
  logic       wrap1, wrap3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_W(2), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .a(a),
    .out(out1), .idx(idx1), .wrap(wrap1)
  );

  onehot_scan_decoder #(.SEL_W(2), .DWELL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .a(a),
    .out(out3), .idx(idx3), .wrap(wrap3)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per instance, whether outputs are lit, whether scanning, the
  // position, how many cycles the position has been shown, and the wrap flag.
  int m_dwell [2] = '{1, 3};
  bit m_on    [2];
  bit m_scan  [2];
  int m_idx   [2];
  int m_age   [2];
  bit m_wrap  [2];
  bit started = 1'b0;

  always @(posedge clk) begin
    bit n_on, n_scan, n_wrap;
    int n_idx, n_age;
    for (int k = 0; k < 2; k++) begin
      n_on = m_on[k]; n_scan = m_scan[k]; n_idx = m_idx[k];
      n_age = m_age[k]; n_wrap = 1'b0;
      if (!rst_n) begin
        n_on = 0; n_scan = 0; n_idx = 0; n_age = 0;
      end else if (!en) begin
        n_on = 0; n_scan = 0; n_age = 0;
      end else if (load) begin
        n_on = 1; n_scan = mode; n_idx = int'(a); n_age = 0;
      end else if (!mode) begin
        n_scan = 0; n_age = 0;
      end else if (!m_scan[k]) begin
        n_on = 1; n_scan = 1; n_age = 0;
      end else begin
        n_age = m_age[k] + 1;
        if (n_age == m_dwell[k]) begin
          n_idx  = (m_idx[k] + 1) % 4;
          n_age  = 0;
          n_wrap = (n_idx == 0);
        end
      end
      m_on[k] <= n_on; m_scan[k] <= n_scan; m_idx[k] <= n_idx;
      m_age[k] <= n_age; m_wrap[k] <= n_wrap;
    end
    started <= 1'b1;
  end

  function automatic int exp_out(input int k);
    return m_on[k] ? (1 << m_idx[k]) : 0;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("dut1.out",  int'(out1),  exp_out(0));
      check("dut1.idx",  int'(idx1),  m_idx[0]);
      check("dut1.wrap", int'(wrap1), int'(m_wrap[0]));
      check("dut3.out",  int'(out3),  exp_out(1));
      check("dut3.idx",  int'(idx3),  m_idx[1]);
      check("dut3.wrap", int'(wrap3), int'(m_wrap[1]));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic [3:0] dec_tab  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] scan_tab [3] = '{4'b1000, 4'b0001, 4'b0010};
  logic       wrap_tab [3] = '{1'b0, 1'b1, 1'b0};
  int wraps;

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b1; a = 2'd3; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit.reset.out", int'(out1), 0);
      check("lit.reset.idx", int'(idx1), 0);
      check("lit.reset.wrap", int'(wrap3), 0);
    end
    rst_n = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    check("lit.release.out", int'(out3), 0);

    // Decode: consecutive loads
    en = 1'b1; mode = 1'b0; load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      tick();
      check("lit.decode.out", int'(out1), int'(dec_tab[i]));
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit.hold.out", int'(out3), 4'b1000);
    end

    // Scan DWELL=1 from a=2
    mode = 1'b1; load = 1'b1; a = 2'd2;
    tick();
    check("lit.scan1.first", int'(out1), 4'b0100);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit.scan1.out", int'(out1), int'(scan_tab[i]));
      check("lit.scan1.wrap", int'(wrap1), int'(wrap_tab[i]));
    end

    // Scan DWELL=3 from idx 0: two wraps in 24 cycles
    load = 1'b1; a = 2'd0;
    tick();
    load = 1'b0;
    wraps = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (wrap3) wraps++;
      if (i == 12) check("lit.scan3.wrap12", int'(wrap3), 1);
      if (i == 11) check("lit.scan3.pre", int'(out3), 4'b1000);
    end
    check("lit.scan3.wraps", wraps, 2);
    tick(3);
    check("lit.scan3.idx1", int'(out3), 4'b0010);

    // Drop enable at idx 1, then resume
    en = 1'b0;
    tick();
    check("lit.off.out", int'(out3), 0);
    check("lit.off.idx", int'(idx3), 1);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit.resume.out", int'(out3), 4'b0010);
    end
    tick();
    check("lit.resume.next", int'(out3), 4'b0100);

    // Freeze via mode=0
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit.freeze.out", int'(out3), 4'b0100);
    end

    // Load mid-dwell restarts the dwell
    mode = 1'b1;
    tick(2);
    load = 1'b1; a = 2'd3;
    tick();
    check("lit.midload.out", int'(out3), 4'b1000);
    load = 1'b0;
    tick(2);
    check("lit.midload.dwell", int'(out3), 4'b1000);
    tick();
    check("lit.midload.wrapout", int'(out3), 4'b0001);
    check("lit.midload.wrap", int'(wrap3), 1);

    // Reset mid-scan
    tick();
    rst_n = 1'b0;
    tick();
    check("lit.midrst.out", int'(out3), 0);
    check("lit.midrst.idx", int'(idx3), 0);
    rst_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
